// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit types, port indices, states.
// Imported by input_route_unit and route_compute.
package noc_pkg;

  localparam logic [1:0] FLIT_BODY     = 2'b00;
  localparam logic [1:0] FLIT_TAIL     = 2'b01;
  localparam logic [1:0] FLIT_HEAD     = 2'b10;
  localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

  localparam int PORT_L    = 0;
  localparam int PORT_E    = 1;
  localparam int PORT_W    = 2;
  localparam int PORT_N    = 3;
  localparam int PORT_S    = 4;
  localparam int NUM_PORTS = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic logic [NUM_PORTS-1:0] port_oh(
    input int idx
  );
    return NUM_PORTS'(1) << idx;
  endfunction

endpackage

// File: rtl/route_compute.sv
// Dimension-ordered route: destination coordinates -> one-hot port.
// Ports: dest_x_i, dest_y_i in; port_o one-hot {S,N,W,E,L} out.
module route_compute
  import noc_pkg::*;
#(
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0,
  parameter int ROUTE_MODE = 0
) (
  input  logic [X_W-1:0]       dest_x_i,
  input  logic [Y_W-1:0]       dest_y_i,
  output logic [NUM_PORTS-1:0] port_o
);

  localparam logic [X_W-1:0] CX = X_W'(CUR_X);
  localparam logic [Y_W-1:0] CY = Y_W'(CUR_Y);

  logic x_gt, x_lt, x_eq;
  logic y_gt, y_lt, y_eq;

  assign x_gt = dest_x_i > CX;
  assign x_lt = dest_x_i < CX;
  assign x_eq = !x_gt && !x_lt;
  assign y_gt = dest_y_i > CY;
  assign y_lt = dest_y_i < CY;
  assign y_eq = !y_gt && !y_lt;

  // Conditions are made mutually exclusive so the
  // decoder stays parallel.
  always_comb begin
    port_o = '0;
    if (ROUTE_MODE == 0) begin
      unique case (1'b1)
        x_gt:         port_o = port_oh(PORT_E);
        x_lt:         port_o = port_oh(PORT_W);
        x_eq && y_gt: port_o = port_oh(PORT_N);
        x_eq && y_lt: port_o = port_oh(PORT_S);
        default:      port_o = port_oh(PORT_L);
      endcase
    end else begin
      unique case (1'b1)
        y_gt:         port_o = port_oh(PORT_N);
        y_lt:         port_o = port_oh(PORT_S);
        y_eq && x_gt: port_o = port_oh(PORT_E);
        y_eq && x_lt: port_o = port_oh(PORT_W);
        default:      port_o = port_oh(PORT_L);
      endcase
    end
  end

endmodule

// File: rtl/input_route_unit.sv
// Per-input route stage: routes heads, holds route per packet, and
// forwards flits through one registered valid/ready stage.
// Ports: clk, reset (async, active-low); in_flit/in_valid/in_ready;
// out_flit/out_valid/out_ready/out_port (one-hot {S,N,W,E,L});
// route_err only when INPUT_ROUTE_ERR_EN is defined.
module input_route_unit
  import noc_pkg::*;
#(
  parameter int FLIT_W     = 8,
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0,
  parameter int ROUTE_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_port
`ifdef INPUT_ROUTE_ERR_EN
  ,
  output logic              route_err
`endif
);

  state_e                state_q, state_d;
  logic [NUM_PORTS-1:0]  route_q, route_d;
  logic [NUM_PORTS-1:0]  port_d;
  logic [NUM_PORTS-1:0]  rc_port;
  logic [FLIT_W-1:0]     out_flit_q;
  logic [NUM_PORTS-1:0]  out_port_q;
  logic                  out_valid_q;
  logic                  accept;
  logic                  fwd;
  logic [1:0]            ftype;
  logic                  is_head;
  logic                  is_tail;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_flit  = out_flit_q;
  assign out_port  = out_port_q;
  assign out_valid = out_valid_q;

  // Type bit 1 marks a head, bit 0 marks packet end.
  assign ftype   = in_flit[FLIT_W-1 -: 2];
  assign is_head = ftype[1];
  assign is_tail = ftype[0];

  route_compute #(
    .X_W        (X_W),
    .Y_W        (Y_W),
    .CUR_X      (CUR_X),
    .CUR_Y      (CUR_Y),
    .ROUTE_MODE (ROUTE_MODE)
  ) u_rc (
    .dest_x_i (in_flit[X_W-1:0]),
    .dest_y_i (in_flit[X_W+Y_W-1:X_W]),
    .port_o   (rc_port)
  );

`ifdef INPUT_ROUTE_ERR_EN
  logic err;
  logic route_err_q;
  assign route_err = route_err_q;
`endif

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    port_d  = route_q;
    fwd     = 1'b1;
`ifdef INPUT_ROUTE_ERR_EN
    err     = 1'b0;
`endif
    if (is_head) begin
      // A head mid-packet simply restarts routing.
      route_d = rc_port;
      port_d  = rc_port;
      state_d = is_tail ? IDLE : ACTIVE;
`ifdef INPUT_ROUTE_ERR_EN
      err     = (state_q == ACTIVE);
`endif
    end else if (state_q == ACTIVE) begin
      state_d = is_tail ? IDLE : ACTIVE;
    end else begin
`ifdef INPUT_ROUTE_ERR_EN
      fwd = 1'b0;
      err = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      route_q     <= '0;
      out_flit_q  <= '0;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef INPUT_ROUTE_ERR_EN
      route_err_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        state_q <= state_d;
        route_q <= route_d;
      end
      if (accept && fwd) begin
        out_valid_q <= 1'b1;
        out_flit_q  <= in_flit;
        out_port_q  <= port_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
`ifdef INPUT_ROUTE_ERR_EN
      route_err_q <= accept && err;
`endif
    end
  end

endmodule

// File: tb/tb_input_route_unit.sv
// Bench for input_route_unit: XY unit at (1,1) with scoreboard,
// plus a YX unit at (1,1) for routing-order checks.
module tb_input_route_unit;
  import noc_pkg::*;

  localparam logic [4:0] PL = 5'b00001;
  localparam logic [4:0] PE = 5'b00010;
  localparam logic [4:0] PW = 5'b00100;
  localparam logic [4:0] PN = 5'b01000;
  localparam logic [4:0] PS = 5'b10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] in_flit = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic [7:0] out_flit;
  logic       out_valid;
  logic [4:0] out_port;

  logic [7:0] in_flit1 = '0;
  logic       in_valid1 = 1'b0;
  logic       out_ready1 = 1'b1;
  logic       in_ready1;
  logic [7:0] out_flit1;
  logic       out_valid1;
  logic [4:0] out_port1;

`ifdef INPUT_ROUTE_ERR_EN
  logic route_err;
  logic route_err1;
`endif

  input_route_unit #(
    .FLIT_W(8), .X_W(2), .Y_W(2),
    .CUR_X(1), .CUR_Y(1), .ROUTE_MODE(0)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_port  (out_port)
`ifdef INPUT_ROUTE_ERR_EN
    ,
    .route_err (route_err)
`endif
  );

  input_route_unit #(
    .FLIT_W(8), .X_W(2), .Y_W(2),
    .CUR_X(1), .CUR_Y(1), .ROUTE_MODE(1)
  ) dut_yx (
    .clk       (clk),
    .reset     (rst_n),
    .in_flit   (in_flit1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .out_flit  (out_flit1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_port  (out_port1)
`ifdef INPUT_ROUTE_ERR_EN
    ,
    .route_err (route_err1)
`endif
  );

  typedef struct packed {
    logic [7:0] flit;
    logic [4:0] port;
  } exp_t;

  typedef struct {
    logic [7:0] flit;
    logic [4:0] port;
    bit         fwd;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
  int run = 0;
  int max_run = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mk(input logic [1:0] t,
                                    input logic [1:0] x,
                                    input logic [1:0] y);
    return {t, 2'b00, y, x};
  endfunction

  // Scoreboard consumer and valid-run tracker.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got flit %0h port %0h want none",
                 out_flit, out_port);
      end else begin
        e = sb.pop_front();
        check("out_flit", {24'd0, out_flit}, {24'd0, e.flit});
        check("out_port", {27'd0, out_port}, {27'd0, e.port});
      end
    end
  end

  task automatic send(input logic [7:0] f,
                      input logic [4:0] p,
                      input bit fwd);
    int k;
    k = 0;
    in_flit  = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("send_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (fwd) sb.push_back('{flit: f, port: p});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    exp_t yx[$];

    tbl.push_back('{mk(FLIT_HEAD, 3, 0), PE, 1});
    tbl.push_back('{mk(FLIT_BODY, 2, 1), PE, 1});
    tbl.push_back('{mk(FLIT_TAIL, 0, 3), PE, 1});
    tbl.push_back('{mk(FLIT_HEADTAIL, 1, 1), PL, 1});
    tbl.push_back('{mk(FLIT_HEADTAIL, 1, 3), PN, 1});
    tbl.push_back('{mk(FLIT_HEADTAIL, 0, 0), PW, 1});
    tbl.push_back('{mk(FLIT_HEADTAIL, 1, 0), PS, 1});
    tbl.push_back('{mk(FLIT_HEADTAIL, 2, 2), PE, 1});
    tbl.push_back('{mk(FLIT_HEAD, 0, 1), PW, 1});
    tbl.push_back('{mk(FLIT_HEAD, 1, 3), PN, 1});
    tbl.push_back('{mk(FLIT_BODY, 3, 3), PN, 1});
    tbl.push_back('{mk(FLIT_HEADTAIL, 1, 0), PS, 1});
    tbl.push_back('{mk(FLIT_HEADTAIL, 3, 3), PE, 1});

    do_reset();
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_port", {27'd0, out_port}, 32'd0);
    check("rst_flit", {24'd0, out_flit}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    foreach (tbl[i]) send(tbl[i].flit, tbl[i].port, tbl[i].fwd);
    idle(3);

    // Backpressure holds the head and blocks the body.
    out_ready = 1'b0;
    send(mk(FLIT_HEAD, 0, 1), PW, 1);
    in_flit  = mk(FLIT_BODY, 2, 3);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_flit", {24'd0, out_flit}, {24'd0, mk(FLIT_HEAD, 0, 1)});
      check("bp_port", {27'd0, out_port}, {27'd0, PW});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(mk(FLIT_BODY, 2, 3), PW, 1);
    send(mk(FLIT_TAIL, 1, 2), PW, 1);
    idle(3);

    // Reset in the middle of a packet.
    send(mk(FLIT_HEAD, 1, 3), PN, 1);
    in_flit = mk(FLIT_BODY, 0, 0);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_port", {27'd0, out_port}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(mk(FLIT_HEAD, 1, 0), PS, 1);
    send(mk(FLIT_TAIL, 3, 3), PS, 1);
    idle(3);

    // Body with no open packet.
    do_reset();
`ifdef INPUT_ROUTE_ERR_EN
    send(mk(FLIT_BODY, 2, 2), 5'b0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("err_pulse", {31'd0, route_err}, 32'd1);
    check("err_no_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("err_clear", {31'd0, route_err}, 32'd0);
    @(posedge clk);
    #1;
`else
    send(mk(FLIT_BODY, 2, 2), 5'b0, 1);
    idle(3);
`endif

    // Ten-flit packet with no bubbles.
    idle(2);
    max_run = 0;
    send(mk(FLIT_HEAD, 3, 3), PE, 1);
    for (int i = 0; i < 8; i++)
      send(mk(FLIT_BODY, 2'(i), 2'(i + 1)), PE, 1);
    send(mk(FLIT_TAIL, 0, 0), PE, 1);
    idle(3);
    check("tput_run", max_run, 32'd10);

    // YX ordering on the second unit.
    yx.push_back('{mk(FLIT_HEADTAIL, 3, 0), PS});
    yx.push_back('{mk(FLIT_HEADTAIL, 1, 1), PL});
    yx.push_back('{mk(FLIT_HEADTAIL, 0, 2), PN});
    yx.push_back('{mk(FLIT_HEADTAIL, 2, 1), PE});
    yx.push_back('{mk(FLIT_HEADTAIL, 0, 0), PS});
    foreach (yx[i]) begin
      in_flit1  = yx[i].flit;
      in_valid1 = 1'b1;
      @(posedge clk);
      #1 in_valid1 = 1'b0;
      @(negedge clk);
      check("yx_valid", {31'd0, out_valid1}, 32'd1);
      check("yx_flit", {24'd0, out_flit1}, {24'd0, yx[i].flit});
      check("yx_port", {27'd0, out_port1}, {27'd0, yx[i].port});
      @(posedge clk);
      #1;
    end

    check("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_route_unit.md
Name: input_route_unit

Overview:
- Parametrised successor of the per-input route-computation stage of a 2D-mesh router.
- Sits between an input port and the per-direction buffers.
- On each head flit, computes a dimension-ordered route from destination coordinates, holds that route for the remaining packet flits, and forwards every flit with a one-hot output-port select through a registered valid/ready stage.

Parameters:
- FLIT_W, 8, flit width in bits.
  - Bits [FLIT_W-1:FLIT_W-2] are the type: 10=HEAD, 00=BODY, 01=TAIL, 11=HEADTAIL.
- X_W, 2, width of the destination X field.
- Y_W, 2, width of the destination Y field.
- CUR_X, 0, this router's X coordinate.
- CUR_Y, 0, this router's Y coordinate.
- ROUTE_MODE, 0, routing order: 0=XY, 1=YX.
- Constraint: FLIT_W >= X_W+Y_W+2.
- Head flit layout: dest_x = [X_W-1:0], dest_y = [X_W+Y_W-1:X_W].

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_flit  in  FLIT_W  incoming flit.
- in_valid  in  1  in_flit is valid.
- in_ready  out  1  block can accept a flit this cycle.
- out_flit  out  FLIT_W  registered flit, unmodified.
- out_valid  out  1  out_flit/out_port are valid.
- out_ready  in  1  downstream buffer accepts this cycle.
- out_port  out  5  one-hot port select: bit0 Local, bit1 East, bit2 West, bit3 North, bit4 South.
- route_err  out  1  protocol-error pulse. Present only with INPUT_ROUTE_ERR_EN.

Behaviour:
- Reset (reset=0, async) sets: out_valid=0, out_flit=0, out_port=0, route_q=0, state=IDLE, route_err=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A flit is accepted when in_valid && in_ready.
  - On accept, out_flit/out_port load next cycle and out_valid=1.
  - Latency: one cycle. Full throughput: one flit per cycle under continuous out_ready.
  - out_valid clears when out_ready && !accept.
  - out_flit/out_port stay stable while out_valid && !out_ready.
- Route function (combinational on head fields):
  - XY mode:
    - dest_x > CUR_X → East
    - dest_x < CUR_X → West
    - else dest_y > CUR_Y → North
    - dest_y < CUR_Y → South
    - else Local
  - YX mode: Y compared first, then X.
  - Comparisons are unsigned.
- State machine (advances only on accept):
  - IDLE:
    - HEAD → compute route, load route_q, out_port = computed route, go to ACTIVE.
    - HEADTAIL → compute route, load route_q, out_port = computed route, stay IDLE.
    - BODY/TAIL → protocol error (see Optional Feature).
  - ACTIVE:
    - BODY → out_port = route_q, stay ACTIVE.
    - TAIL → out_port = route_q, go to IDLE.
    - HEAD/HEADTAIL → protocol error. Treated as a new head: reroute and reload route_q. HEAD stays ACTIVE; HEADTAIL goes to IDLE.
- No accept: state, route_q and the output register hold.
- Reset mid-packet returns to IDLE. The next flit must be a head.
- route_q is updated only by heads.

Optional Feature:
- Macro: INPUT_ROUTE_ERR_EN.
- Defined:
  - A BODY/TAIL accepted in IDLE is dropped: out_valid is not set for it.
  - route_err pulses high for exactly one cycle (the cycle after accept).
  - A head accepted in ACTIVE is forwarded and rerouted as described, and also pulses route_err.
- Undefined:
  - route_err port does not exist.
  - BODY/TAIL in IDLE is forwarded with out_port = route_q (last route, 0 after reset). State stays IDLE.

Decomposition:
- Shared package noc_pkg holds:
  - flit type constants FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_HEADTAIL;
  - port index constants PORT_L/E/W/N/S and NUM_PORTS=5;
  - state encodings IDLE/ACTIVE.
- Sub-module route_compute: pure combinational dest→one-hot port, parametrised by CUR_X, CUR_Y, X_W, Y_W, ROUTE_MODE. It is reused by the output allocator's lookahead.

Test Plan (CUR_X=1, CUR_Y=1, out_ready=1 unless stated):
1. XY routing: HEAD dest(x=3,y=0), BODY, TAIL back-to-back → three outputs, each out_port=5'b00010 (East), one cycle after each accept; state returns to IDLE.
2. YX routing: ROUTE_MODE=1, HEADTAIL dest(x=3,y=0) → out_port=5'b10000 (South). HEADTAIL dest(1,1) → 5'b00001 (Local).
3. Backpressure: out_ready=0 for 3 cycles after HEAD dest(0,1) → in_ready=0; out_flit stable; out_port=5'b00100 (West). Release → BODY accepted the next cycle with the same port.
4. Reset mid-packet: after HEAD dest(1,3), assert reset during BODY → out_valid=0 and out_port=0 immediately. After release, HEAD dest(1,0) → 5'b10000.
5. Protocol error, macro defined: BODY in IDLE → no out_valid, route_err=1 for one cycle. Undefined: BODY forwarded with out_port=0 after reset.
6. Throughput: a 10-flit packet streamed with continuous valid/ready → 10 consecutive out_valid cycles, no bubbles.
